// File: rtl/instr_data_mem.sv
// Shared instruction/data word RAM with two independent wait-state read ports.
// Define MEM_WRITE_PROTECT_EN to drop and flag writes below TEXT_LIMIT.

module instr_data_mem_rd #(
  parameter int WORD_ADDR_W = 14,
  parameter int READ_WAIT   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            word_i,
  output logic [WORD_ADDR_W-1:0] idx_o,
  output logic [31:0]            rdata_o,
  output logic                   valid_o,
  output logic                   err_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;
  logic        oor;

  assign oor   = |(addr_q >> (WORD_ADDR_W + 2));
  assign idx_o = addr_q[WORD_ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  // A new request always wins: it restarts latency and drops the old read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_o   = 1'b0;
    if (req_i) begin
      state_d = S_WAIT;
      cnt_d   = 2'(READ_WAIT);
      addr_d  = addr_i;
    end else if (state_q == S_WAIT) begin
      if (cnt_q == 2'd0) begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        rdata_d = oor ? 32'h0 : word_i;
        err_o   = oor;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  assign rdata_o = rdata_q;
  assign valid_o = valid_q;

endmodule

module instr_data_mem #(
  parameter int          WORD_ADDR_W = 14,
  parameter int          READ_WAIT   = 0,
  parameter logic [31:0] TEXT_LIMIT  = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        instr_valid,
  output logic        data_valid,
  output logic        err
);

  localparam int DEPTH = 2 ** WORD_ADDR_W;

  logic [31:0] mem_q [DEPTH];

  logic [WORD_ADDR_W-1:0] i_idx, d_idx, w_idx;
  logic [31:0]            i_word, d_word;
  logic                   i_err, d_err, d_req;
  logic                   wr_en, wr_oor, wr_prot;
  logic                   text_hit, wr_ok, wr_err;
  logic                   err_q, err_d;

  assign wr_en    = |data_write;
  assign d_req    = data_read & ~wr_en;
  assign w_idx    = data_addr[WORD_ADDR_W+1:2];
  assign wr_oor   = |(data_addr >> (WORD_ADDR_W + 2));
  assign text_hit = data_addr < TEXT_LIMIT;

`ifdef MEM_WRITE_PROTECT_EN
  assign wr_prot = text_hit;
`else
  // TEXT_LIMIT is inert in this build.
  assign wr_prot = text_hit & 1'b0;
`endif

  assign wr_ok  = wr_en & ~wr_oor & ~wr_prot;
  assign wr_err = wr_en & (wr_oor | wr_prot);

  assign i_word = mem_q[i_idx];
  assign d_word = mem_q[d_idx];

  instr_data_mem_rd #(
    .WORD_ADDR_W (WORD_ADDR_W),
    .READ_WAIT   (READ_WAIT)
  ) u_irf (
    .clk     (clk),
    .rst     (rst),
    .req_i   (instr_read),
    .addr_i  (instr_addr),
    .word_i  (i_word),
    .idx_o   (i_idx),
    .rdata_o (instr_out),
    .valid_o (instr_valid),
    .err_o   (i_err)
  );

  instr_data_mem_rd #(
    .WORD_ADDR_W (WORD_ADDR_W),
    .READ_WAIT   (READ_WAIT)
  ) u_drd (
    .clk     (clk),
    .rst     (rst),
    .req_i   (d_req),
    .addr_i  (data_addr),
    .word_i  (d_word),
    .idx_o   (d_idx),
    .rdata_o (data_out),
    .valid_o (data_valid),
    .err_o   (d_err)
  );

  // Array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (data_write[b]) begin
          mem_q[w_idx][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  assign err_d = err_q | wr_err | i_err | d_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_instr_data_mem.sv
// Directed bench for instr_data_mem: u0 has READ_WAIT=0, u2 has READ_WAIT=2.
// Both share one stimulus stream; MEM_WRITE_PROTECT_EN selects expectations.

module tb_instr_data_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_read = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        data_read = 1'b0;
  logic [3:0]  data_write = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_in = '0;

  logic [31:0] i_out0, d_out0, i_out2, d_out2;
  logic        i_v0, d_v0, err0, i_v2, d_v2, err2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_data_mem #(.READ_WAIT(0)) u0 (
    .clk         (clk),
    .rst         (rst),
    .instr_read  (instr_read),
    .instr_addr  (instr_addr),
    .instr_out   (i_out0),
    .data_read   (data_read),
    .data_write  (data_write),
    .data_addr   (data_addr),
    .data_in     (data_in),
    .data_out    (d_out0),
    .instr_valid (i_v0),
    .data_valid  (d_v0),
    .err         (err0)
  );

  instr_data_mem #(.READ_WAIT(2)) u2 (
    .clk         (clk),
    .rst         (rst),
    .instr_read  (instr_read),
    .instr_addr  (instr_addr),
    .instr_out   (i_out2),
    .data_read   (data_read),
    .data_write  (data_write),
    .data_addr   (data_addr),
    .data_in     (data_in),
    .data_out    (d_out2),
    .instr_valid (i_v2),
    .data_valid  (d_v2),
    .err         (err2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0]  be);
    data_addr  = a;
    data_in    = d;
    data_write = be;
    step();
    data_write = '0;
  endtask

  // Issue a data read; after return u0's result is visible.
  task automatic drd(input logic [31:0] a);
    data_addr = a;
    data_read = 1'b1;
    step();
    data_read = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [31:0] pre;

    idle(2);
    chk("rst_iout", i_out2, 32'h0);
    chk("rst_dout", d_out2, 32'h0);
    chk("rst_ival", {31'b0, i_v2}, 32'h0);
    chk("rst_dval", {31'b0, d_v2}, 32'h0);
    chk("rst_err", {31'b0, err0}, 32'h0);
    rst = 1'b1;
    step();

    // Full write, unaligned read, latency on both instances
    wr(32'h4000, 32'hDEADBEEF, 4'hF);
    data_addr = 32'h4002;
    data_read = 1'b1;
    step();
    data_read = 1'b0;
    chk("w0_dval_early", {31'b0, d_v0}, 32'h0);
    step();
    chk("w0_dval", {31'b0, d_v0}, 32'h1);
    chk("w0_dout", d_out0, 32'hDEADBEEF);
    chk("w2_dval_e1", {31'b0, d_v2}, 32'h0);
    step();
    chk("w0_dval_pulse", {31'b0, d_v0}, 32'h0);
    chk("w0_dout_hold", d_out0, 32'hDEADBEEF);
    chk("w2_dval_e2", {31'b0, d_v2}, 32'h0);
    step();
    chk("w2_dval_e3", {31'b0, d_v2}, 32'h1);
    chk("w2_dout", d_out2, 32'hDEADBEEF);
    step();

    // Byte lane 2 write
    wr(32'h4000, 32'h11223344, 4'hF);
    wr(32'h4000, 32'hAAAAAAAA, 4'b0100);
    drd(32'h4000);
    chk("lane_u0", d_out0, 32'h11AA3344);
    idle(2);
    chk("lane_u2", d_out2, 32'h11AA3344);
    chk("lane_u2v", {31'b0, d_v2}, 32'h1);

    // Instruction latency and restart
    wr(32'h4004, 32'h55667788, 4'hF);
    instr_addr = 32'h4000;
    instr_read = 1'b1;
    step();
    instr_read = 1'b0;
    step();
    chk("i0_val", {31'b0, i_v0}, 32'h1);
    chk("i0_out", i_out0, 32'h11AA3344);
    chk("i2_val_e1", {31'b0, i_v2}, 32'h0);
    step();
    chk("i2_val_e2", {31'b0, i_v2}, 32'h0);
    step();
    chk("i2_val_e3", {31'b0, i_v2}, 32'h1);
    chk("i2_out", i_out2, 32'h11AA3344);
    step();
    instr_read = 1'b1;
    step();
    instr_read = 1'b0;
    step();
    instr_addr = 32'h4004;
    instr_read = 1'b1;
    step();
    instr_read = 1'b0;
    pulses = 0;
    for (int k = 3; k <= 6; k++) begin
      step();
      if (i_v2) pulses++;
      chk($sformatf("rs_val_e%0d", k), {31'b0, i_v2},
          (k == 5) ? 32'h1 : 32'h0);
      if (k == 3) chk("rs_hold", i_out2, 32'h11AA3344);
      if (k == 5) chk("rs_out", i_out2, 32'h55667788);
    end
    chk("rs_pulses", pulses, 32'd1);

    // Same-edge write vs instr result
    wr(32'h4008, 32'h01020304, 4'hF);
    instr_addr = 32'h4008;
    instr_read = 1'b1;
    step();
    instr_read = 1'b0;
    data_addr  = 32'h4008;
    data_in    = 32'h0A0B0C0D;
    data_write = 4'hF;
    step();
    data_write = '0;
    chk("coll_u0", i_out0, 32'h01020304);
    idle(2);
    chk("coll_u2", i_out2, 32'h0A0B0C0D);
    step();

    // Write with simultaneous read
    data_addr  = 32'h400C;
    data_in    = 32'h12345678;
    data_write = 4'hF;
    data_read  = 1'b1;
    step();
    data_write = '0;
    data_read  = 1'b0;
    step();
    chk("wr_rd_noval", {31'b0, d_v0}, 32'h0);
    chk("wr_rd_hold", d_out0, 32'h11AA3344);
    chk("wr_rd_err", {31'b0, err0}, 32'h0);
    drd(32'h400C);
    chk("wr_rd_data", d_out0, 32'h12345678);
    idle(3);

    // Text region write
    drd(32'h0000_0010);
    pre = d_out0;
    wr(32'h0000_0010, 32'hCAFEF00D, 4'hF);
    drd(32'h0000_0010);
`ifdef MEM_WRITE_PROTECT_EN
    chk("prot_data", d_out0, pre);
    chk("prot_err", {31'b0, err0}, 32'h1);
`else
    chk("prot_data", d_out0, 32'hCAFEF00D);
    chk("prot_err", {31'b0, err0}, 32'h0);
    chk("prot_pre", {31'b0, pre === 32'hCAFEF00D},
        32'h0);
`endif
    idle(3);

    // Out-of-range accesses
    drd(32'h8000_0000);
    chk("oor_dout", d_out0, 32'h0);
    chk("oor_dval", {31'b0, d_v0}, 32'h1);
    chk("oor_err", {31'b0, err0}, 32'h1);
    idle(2);
    chk("oor_dout2", d_out2, 32'h0);
    chk("oor_err2", {31'b0, err2}, 32'h1);
    wr(32'h0001_4000, 32'hFFFFFFFF, 4'hF);
    drd(32'h4000);
    chk("oor_wr_drop", d_out0, 32'h11AA3344);
    chk("oor_sticky", {31'b0, err0}, 32'h1);
    idle(3);

    // Reset mid-wait
    wr(32'h4010, 32'h600DF00D, 4'hF);
    instr_addr = 32'h4010;
    instr_read = 1'b1;
    data_addr  = 32'h4010;
    data_read  = 1'b1;
    step();
    instr_read = 1'b0;
    data_read  = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("mr_iout", i_out2, 32'h0);
    chk("mr_dout", d_out2, 32'h0);
    chk("mr_iout0", i_out0, 32'h0);
    chk("mr_err", {31'b0, err0}, 32'h0);
    chk("mr_err2", {31'b0, err2}, 32'h0);
    step();
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (i_v2 || d_v2) pulses++;
    end
    chk("mr_nopulse", pulses, 32'd0);
    drd(32'h4010);
    chk("mr_keep", d_out0, 32'h600DF00D);
    instr_addr = 32'h4000;
    instr_read = 1'b1;
    step();
    instr_read = 1'b0;
    step();
    chk("mr_keep_i", i_out0, 32'h11AA3344);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_data_mem.md
INSTR_DATA_MEM -- requirements
Module: instr_data_mem

Interface
REQ-001 Parameter WORD_ADDR_W, default 14, SHALL set the array depth to 2**WORD_ADDR_W 32-bit words.
REQ-002 Parameter READ_WAIT, default 0, range 0..3, SHALL set the number of extra wait cycles added to every read.
REQ-003 Parameter TEXT_LIMIT, default 32'h0000_4000, SHALL set the byte address bound of the protected text region: addresses below TEXT_LIMIT are protected.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port instr_read, input, 1: instruction read request, sampled each rising edge.
REQ-007 Port instr_addr, input, 32: instruction byte address.
REQ-008 Port instr_out, output, 32: registered instruction word.
REQ-009 Port data_read, input, 1: data read request.
REQ-010 Port data_write, input, 4: byte write enables; bit n writes byte lane n, bits [8n+7:8n].
REQ-011 Port data_addr, input, 32: data byte address.
REQ-012 Port data_in, input, 32: write data, already lane-replicated by the initiator.
REQ-013 Port data_out, output, 32: registered data word.
REQ-014 Port instr_valid, output, 1: one-cycle pulse when instr_out updates.
REQ-015 Port data_valid, output, 1: one-cycle pulse when data_out updates.
REQ-016 Port err, output, 1: sticky error flag.

Function
REQ-017 Word index SHALL be addr[WORD_ADDR_W+1:2]; addr[1:0] SHALL be ignored for selection, and reads SHALL always return the full word.
REQ-018 Out-of-range address is any address with nonzero bits [31:WORD_ADDR_W+2]; such a read SHALL return 32'h0 and set err, and such a write SHALL be dropped and set err.
REQ-019 Each read port SHALL run an independent FSM, IDLE -> WAIT -> IDLE, with a 2-bit wait counter.
- Request sampled in IDLE with READ_WAIT=0: output word and valid pulse on the next edge.
- With READ_WAIT=N: counter loads N, and the word plus valid pulse appear N+1 edges after the sampling edge.
REQ-020 A new request sampled while in WAIT SHALL restart the latency with the new address; the pending read is discarded and no valid pulse is issued for it.
REQ-021 The array word SHALL be sampled at the edge the result is produced, so the latest written value is returned.
REQ-022 instr_out and data_out SHALL hold their last value while idle.
REQ-023 A write SHALL complete on the edge where data_write is nonzero, updating only the enabled lanes, with no wait cycles.
REQ-024 Same-edge data write and instruction read-result to the same word: the read SHALL return the pre-write word.
REQ-025 data_write nonzero together with data_read=1: the write SHALL be performed, the read request ignored, and err left unchanged.
REQ-026 Once set, err SHALL stay at 1 until reset.

Reset
REQ-027 rst=0 SHALL immediately force instr_out=0, data_out=0, instr_valid=0, data_valid=0, err=0, both FSMs to IDLE, and counters to 0.
REQ-028 Reset during WAIT SHALL cancel the pending read; no valid pulse follows deassertion.
REQ-029 Array contents SHALL NOT be affected by reset.

Configuration
REQ-030 With macro MEM_WRITE_PROTECT_EN defined, any write whose address is below TEXT_LIMIT SHALL be dropped and SHALL set err.
REQ-031 Without MEM_WRITE_PROTECT_EN, writes to all in-range addresses SHALL be performed and TEXT_LIMIT SHALL have no effect.

Verification
REQ-032 READ_WAIT=0: write 32'hDEADBEEF with data_write=4'b1111 to 32'h4000, then data_read at 32'h4002 -> data_out=32'hDEADBEEF with data_valid one edge later.
REQ-033 Byte write 4'b0100 with data_in=32'hAAAAAAAA to word 32'h4000 holding 32'h11223344 -> read returns 32'h11AA3344.
REQ-034 READ_WAIT=2: instr_read at 32'h4000 -> instr_valid on the third edge; a second request at 32'h4004 on edge 2 -> only one pulse, carrying the 32'h4004 word.
REQ-035 data_read at 32'h8000_0000 -> data_out=0, err=1, and err remains 1 after later good accesses.
REQ-036 MEM_WRITE_PROTECT_EN defined: write to 32'h0000_0010 -> word unchanged, err=1; without the macro -> word updated, err=0.
REQ-037 Assert rst=0 mid-WAIT -> outputs 0 at once, no valid pulse after release, array data intact.
